rx_dma_scheduler: RTL and testbench
===================================

// Module: rx_dma_scheduler
// PURPOSE
//  Per-packet sequencer between the RX meta FIFO and dma_master_engine. Pops one descriptor (payload byte length),
//  picks the next free slot of a host DDR receive ring, starts one DMA transfer draining that packet from the PBM,
//  then posts a completion record. Oversize packets go to a discard address so the PBM stays aligned; host returns slots via credits.
// PARAMETERS
//  NUM_SLOTS        16     ring slots (power of two, 2..256)
//  SLOT_BYTES_LOG2  11     log2 slot size in bytes (2048 B slots)
//  TIMEOUT_CYCLES   65536  max cycles from DMA start to done before HALT
// PORTS
//  clk              in   1   clock
//  rst              in   1   asynchronous reset, active-high
//  i_enable         in   1   CSR run bit; 0 returns the FSM to IDLE between packets and reloads credits
//  i_ring_base      in   32  ring base byte address (slot-size aligned)
//  i_discard_addr   in   32  sink address for oversize packets
//  i_meta_empty     in   1   meta FIFO empty
//  i_meta_data      in   16  meta FIFO read data (payload bytes), valid the cycle after o_meta_ren
//  o_meta_ren       out  1   meta FIFO pop (1-cycle pulse)
//  o_dma_start      out  1   DMA start pulse
//  o_dma_addr       out  32  DMA destination byte address
//  o_dma_len        out  32  DMA length in bytes
//  i_dma_done       in   1   DMA done pulse
//  i_slot_release   in   1   host frees one slot (1-cycle pulse)
//  o_cpl_valid      out  1   completion record valid
//  o_cpl_slot       out  8   slot index used (0 when dropped)
//  o_cpl_len        out  16  payload byte length from meta
//  o_cpl_drop       out  1   1 = oversize or zero-length packet, not delivered
//  i_cpl_ready      in   1   completion consumer ready
//  o_credits        out  9   free slots
//  o_drop_cnt       out  16  dropped packets, saturating
//  o_timeout        out  1   sticky: DMA done never arrived
//  o_credit_err     out  1   sticky: release received while credits == NUM_SLOTS
// BEHAVIOUR
//  Reset: state IDLE, all pulses/valids 0, o_dma_addr/len 0, head 0, o_credits NUM_SLOTS, counters and stickies 0.
//  States: IDLE -> POP -> LOAD -> {START | CPL} -> WAIT -> CPL -> IDLE; HALT is terminal.
//  IDLE: go to POP when i_enable & !i_meta_empty & o_credits != 0. i_enable low in IDLE: credits := NUM_SLOTS, head := 0,
//    stickies cleared.
//  POP: o_meta_ren = 1 for exactly one cycle. LOAD: capture i_meta_data as len.
//  LOAD classification:
//    len == 0 -> CPL with drop=1 and no DMA (the PBM holds nothing for the packet).
//    len > 2**SLOT_BYTES_LOG2 -> START with addr = i_discard_addr and drop=1. No credit consumed.
//    otherwise -> START with addr = i_ring_base + (head << SLOT_BYTES_LOG2) and drop=0.
//  START: o_dma_start = 1 for one cycle; o_dma_len = {16'd0, (len + 3) & ~3} (round up to a whole word).
//    o_dma_addr/o_dma_len stay held until the next START.
//  Non-drop START consumes one credit and sets head := (head + 1) mod NUM_SLOTS. o_cpl_slot records the pre-increment head.
//  WAIT: wait for i_dma_done, then go to CPL. The timeout counter resets in START.
//    When it reaches TIMEOUT_CYCLES-1: set o_timeout and go to HALT. Only rst exits HALT.
//  CPL: o_cpl_valid held with a stable record until i_cpl_ready; the handshake cycle returns to IDLE.
//    Drop completion increments o_drop_cnt, saturating at 16'hFFFF.
//  Credits: a release and a consume in the same cycle give a net change of 0.
//    A release at NUM_SLOTS is ignored and sets o_credit_err. A consume never happens at 0, because IDLE gates it.
//  i_enable deassert mid-packet: the current packet completes normally; the FSM then parks in IDLE.
//  i_dma_done outside WAIT is ignored. Latency from meta non-empty to o_dma_start is 4 cycles (IDLE, POP, LOAD, START).
// TESTING
//  Reset, enable, meta=64: ren@t+1, start@t+3 with addr=base+0 and len=64. After done, cpl slot0, len64, drop0; credits=15.
//  17 packets of 100 B, no releases: 16 DMAs with len=100 to slots 0..15. Packet 17 is stalled, credits=0.
//    One release lets packet 17 go to slot 0 (wrap).
//  meta=3000: DMA to discard_addr with len=3000; cpl drop=1; drop_cnt=1; credits unchanged.
//    meta=0: no start, cpl drop=1, drop_cnt=2.
//  meta=61: o_dma_len=64, o_cpl_len=61.
//  Release and start in the same cycle at credits=5 -> credits stay 5. Release at 16 -> credit_err=1, credits stay 16.
//  Withhold done for TIMEOUT_CYCLES -> o_timeout=1 and FSM HALT, no further ren. Assert rst mid-WAIT -> all outputs at reset values.
//  i_cpl_ready low for 10 cycles -> record stable, no new ren until accepted.

Source files
------------

// File: rtl/rx_dma_scheduler_if.sv
// Handshake bundle between rx_dma_scheduler and its meta FIFO, DMA engine and
// completion consumer. master = scheduler side, slave = environment side.
interface rx_dma_scheduler_if;
    logic        i_meta_empty;
    logic [15:0] i_meta_data;
    logic        o_meta_ren;
    logic        o_dma_start;
    logic [31:0] o_dma_addr;
    logic [31:0] o_dma_len;
    logic        i_dma_done;
    logic        o_cpl_valid;
    logic [7:0]  o_cpl_slot;
    logic [15:0] o_cpl_len;
    logic        o_cpl_drop;
    logic        i_cpl_ready;

    modport master (
        input  i_meta_empty, i_meta_data, i_dma_done, i_cpl_ready,
        output o_meta_ren, o_dma_start, o_dma_addr, o_dma_len,
        output o_cpl_valid, o_cpl_slot, o_cpl_len, o_cpl_drop
    );

    modport slave (
        output i_meta_empty, i_meta_data, i_dma_done, i_cpl_ready,
        input  o_meta_ren, o_dma_start, o_dma_addr, o_dma_len,
        input  o_cpl_valid, o_cpl_slot, o_cpl_len, o_cpl_drop
    );
endinterface

// File: rtl/rx_dma_scheduler.sv
// Per-packet RX sequencer: pops a length descriptor, assigns a host ring slot
// (or the discard sink), issues one DMA and posts a completion record.
module rx_dma_scheduler #(
    parameter int unsigned NUM_SLOTS       = 16,
    parameter int unsigned SLOT_BYTES_LOG2 = 11,
    parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [31:0]         i_ring_base,
    input  logic [31:0]         i_discard_addr,
    input  logic                i_slot_release,
    rx_dma_scheduler_if.master  bus,
    output logic [8:0]          o_credits,
    output logic [15:0]         o_drop_cnt,
    output logic                o_timeout,
    output logic                o_credit_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LOAD, S_START, S_WAIT, S_CPL, S_HALT
    } state_t;

    localparam logic [8:0]  CREDITS_FULL = 9'(NUM_SLOTS);
    localparam logic [7:0]  HEAD_MASK    = 8'(NUM_SLOTS - 1);
    localparam logic [31:0] SLOT_BYTES   = 32'(1) << SLOT_BYTES_LOG2;
    localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        meta_ren_q, meta_ren_d;
    logic        dma_start_q, dma_start_d;
    logic [31:0] dma_addr_q, dma_addr_d;
    logic [31:0] dma_len_q, dma_len_d;
    logic        cpl_valid_q, cpl_valid_d;
    logic [7:0]  cpl_slot_q, cpl_slot_d;
    logic [15:0] cpl_len_q, cpl_len_d;
    logic        cpl_drop_q, cpl_drop_d;
    logic [7:0]  head_q, head_d;
    logic [8:0]  credits_q, credits_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        timeout_q, timeout_d;
    logic        credit_err_q, credit_err_d;
    logic [31:0] tmo_q, tmo_d;

    logic        consume;
    logic        release_ok;
    logic        oversize;
    logic [15:0] round_len;

    assign release_ok = i_slot_release && (credits_q != CREDITS_FULL);
    assign oversize   = 32'(bus.i_meta_data) > SLOT_BYTES;
    assign round_len  = (bus.i_meta_data + 16'd3) & ~16'd3;

    always_comb begin
        state_d      = state_q;
        meta_ren_d   = 1'b0;
        dma_start_d  = 1'b0;
        dma_addr_d   = dma_addr_q;
        dma_len_d    = dma_len_q;
        cpl_valid_d  = cpl_valid_q;
        cpl_slot_d   = cpl_slot_q;
        cpl_len_d    = cpl_len_q;
        cpl_drop_d   = cpl_drop_q;
        head_d       = head_q;
        drop_cnt_d   = drop_cnt_q;
        timeout_d    = timeout_q;
        credit_err_d = credit_err_q;
        tmo_d        = tmo_q;
        consume      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_enable && !bus.i_meta_empty && credits_q != '0) begin
                    state_d    = S_POP;
                    meta_ren_d = 1'b1;
                end
            end
            S_POP: state_d = S_LOAD;
            S_LOAD: begin
                // Meta data arrives this cycle; classify it directly so START follows LOAD.
                cpl_len_d = bus.i_meta_data;
                if (bus.i_meta_data == '0) begin
                    state_d     = S_CPL;
                    cpl_valid_d = 1'b1;
                    cpl_drop_d  = 1'b1;
                    cpl_slot_d  = '0;
                end else begin
                    state_d     = S_START;
                    dma_start_d = 1'b1;
                    dma_len_d   = {16'd0, round_len};
                    if (oversize) begin
                        dma_addr_d = i_discard_addr;
                        cpl_drop_d = 1'b1;
                        cpl_slot_d = '0;
                    end else begin
                        dma_addr_d = i_ring_base + (32'(head_q) << SLOT_BYTES_LOG2);
                        cpl_drop_d = 1'b0;
                        cpl_slot_d = head_q;
                        head_d     = (head_q + 8'd1) & HEAD_MASK;
                        consume    = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (bus.i_dma_done) begin
                    state_d     = S_CPL;
                    cpl_valid_d = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_CPL: begin
                if (bus.i_cpl_ready) begin
                    state_d     = S_IDLE;
                    cpl_valid_d = 1'b0;
                    if (cpl_drop_q && drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE && !i_enable) begin
            credits_d    = CREDITS_FULL;
            head_d       = '0;
            timeout_d    = 1'b0;
            credit_err_d = 1'b0;
        end else begin
            if (i_slot_release && credits_q == CREDITS_FULL) begin
                credit_err_d = 1'b1;
            end
            credits_d = credits_q + 9'(release_ok) - 9'(consume);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            meta_ren_q   <= 1'b0;
            dma_start_q  <= 1'b0;
            dma_addr_q   <= '0;
            dma_len_q    <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_slot_q   <= '0;
            cpl_len_q    <= '0;
            cpl_drop_q   <= 1'b0;
            head_q       <= '0;
            credits_q    <= CREDITS_FULL;
            drop_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            credit_err_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            meta_ren_q   <= meta_ren_d;
            dma_start_q  <= dma_start_d;
            dma_addr_q   <= dma_addr_d;
            dma_len_q    <= dma_len_d;
            cpl_valid_q  <= cpl_valid_d;
            cpl_slot_q   <= cpl_slot_d;
            cpl_len_q    <= cpl_len_d;
            cpl_drop_q   <= cpl_drop_d;
            head_q       <= head_d;
            credits_q    <= credits_d;
            drop_cnt_q   <= drop_cnt_d;
            timeout_q    <= timeout_d;
            credit_err_q <= credit_err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.o_meta_ren  = meta_ren_q;
    assign bus.o_dma_start = dma_start_q;
    assign bus.o_dma_addr  = dma_addr_q;
    assign bus.o_dma_len   = dma_len_q;
    assign bus.o_cpl_valid = cpl_valid_q;
    assign bus.o_cpl_slot  = cpl_slot_q;
    assign bus.o_cpl_len   = cpl_len_q;
    assign bus.o_cpl_drop  = cpl_drop_q;
    assign o_credits       = credits_q;
    assign o_drop_cnt      = drop_cnt_q;
    assign o_timeout       = timeout_q;
    assign o_credit_err    = credit_err_q;

endmodule

// File: tb/tb_rx_dma_scheduler.sv
// Scoreboard bench for rx_dma_scheduler: a packet-level model queues the
// expected DMA and completion records; a negedge monitor pops and compares.
module tb_rx_dma_scheduler;
    localparam int NS  = 16;
    localparam int SBL = 11;
    localparam int TMO = 200;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] DISC = 32'hDEAD_BE00;

    typedef struct { logic [31:0] addr; logic [31:0] len; } dma_t;
    typedef struct { logic [7:0] slot; logic [15:0] len; logic drop; } cpl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        release_p = 1'b0;
    logic [31:0] ring_base = BASE;
    logic [31:0] discard = DISC;
    logic [8:0]  credits;
    logic [15:0] drop_cnt;
    logic        timeout;
    logic        credit_err;
    logic        done_en = 1'b1;

    rx_dma_scheduler_if bus();

    rx_dma_scheduler #(
        .NUM_SLOTS(NS), .SLOT_BYTES_LOG2(SBL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(enable),
        .i_ring_base(ring_base), .i_discard_addr(discard),
        .i_slot_release(release_p), .bus(bus),
        .o_credits(credits), .o_drop_cnt(drop_cnt),
        .o_timeout(timeout), .o_credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int ren_cnt = 0, cpl_cnt = 0, cpl_ok_cnt = 0;
    int m_head = 0, m_cons = 0, m_rel = 0, m_drops = 0, m_pushed = 0;
    logic [15:0] meta_q[$];
    dma_t exp_dma_q[$];
    cpl_t exp_cpl_q[$];
    dma_t mon_d;
    cpl_t mon_c;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Meta FIFO model.
    always @(posedge clk) begin
        cyc++;
        if (rst) bus.i_meta_data <= '0;
        else if (bus.o_meta_ren && meta_q.size() > 0) bus.i_meta_data <= meta_q.pop_front();
    end
    always @(negedge clk) bus.i_meta_empty <= (meta_q.size() == 0);

    // DMA engine: done pulse 1..5 cycles into WAIT.
    initial begin
        int d;
        bus.i_dma_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_dma_start && done_en) begin
                d = int'($urandom_range(0, 4));
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1 bus.i_dma_done = 1'b1;
                @(posedge clk);
                #1 bus.i_dma_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            ren_cnt = 0; cpl_cnt = 0; cpl_ok_cnt = 0;
        end else begin
            if (bus.o_meta_ren) ren_cnt++;
            if (bus.o_dma_start) begin
                chk("dma_expected", longint'(exp_dma_q.size() != 0), 1);
                if (exp_dma_q.size() != 0) begin
                    mon_d = exp_dma_q.pop_front();
                    chk("dma_addr", bus.o_dma_addr, mon_d.addr);
                    chk("dma_len", bus.o_dma_len, mon_d.len);
                end
            end
            if (bus.o_cpl_valid) begin
                chk("cpl_expected", longint'(exp_cpl_q.size() != 0), 1);
                if (exp_cpl_q.size() != 0) begin
                    mon_c = exp_cpl_q[0];
                    chk("cpl_slot", bus.o_cpl_slot, mon_c.slot);
                    chk("cpl_len", bus.o_cpl_len, mon_c.len);
                    chk("cpl_drop", bus.o_cpl_drop, mon_c.drop);
                    if (bus.i_cpl_ready) begin
                        void'(exp_cpl_q.pop_front());
                        cpl_cnt++;
                        if (!mon_c.drop) cpl_ok_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet-level model: slot = running count of delivered packets mod NS.
    task automatic push_pkt(input int len, input bit want_cpl);
        bit   drop;
        dma_t d;
        cpl_t c;
        drop = (len == 0) || (len > (1 << SBL));
        if (len != 0) begin
            d.addr = drop ? DISC : BASE + 32'(m_head * (1 << SBL));
            d.len  = 32'(((len + 3) / 4) * 4);
            exp_dma_q.push_back(d);
        end
        if (want_cpl) begin
            c.slot = drop ? 8'd0 : 8'(m_head);
            c.len  = 16'(len);
            c.drop = drop;
            exp_cpl_q.push_back(c);
            if (drop) m_drops++;
        end
        if (!drop) begin
            m_head = (m_head + 1) % NS;
            m_cons++;
        end
        meta_q.push_back(16'(len));
        m_pushed++;
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return 2048;
            2:       return 2049;
            3:       return int'($urandom_range(2050, 4000));
            4:       return int'($urandom_range(1, 4));
            default: return int'($urandom_range(1, 2048));
        endcase
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_ren"}, bus.o_meta_ren, 0);
        chk({tag, "_start"}, bus.o_dma_start, 0);
        chk({tag, "_addr"}, bus.o_dma_addr, 0);
        chk({tag, "_len"}, bus.o_dma_len, 0);
        chk({tag, "_cpl_valid"}, bus.o_cpl_valid, 0);
        chk({tag, "_credits"}, credits, NS);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_credit_err"}, credit_err, 0);
    endtask

    task automatic clear_model();
        meta_q.delete();
        exp_dma_q.delete();
        exp_cpl_q.delete();
        m_head = 0; m_cons = 0; m_rel = 0; m_drops = 0; m_pushed = 0;
    endtask

    task automatic do_reset(input bit with_checks);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        if (with_checks) reset_checks("reset");
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_dma_q.size() == 0 && exp_cpl_q.size() == 0 && meta_q.size() == 0) break;
        end
        chk({tag, "_drained"}, longint'(i < 4000), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_ren_count"}, ren_cnt, m_pushed);
        chk({tag, "_credits"}, credits, NS - m_cons + m_rel);
        chk({tag, "_drop_cnt"}, drop_cnt, m_drops);
    endtask

    task automatic reload(input string tag);
        tick();
        enable = 1'b0;
        tick();
        tick();
        chk({tag, "_reload_credits"}, credits, NS);
        enable = 1'b1;
        m_head = 0; m_cons = 0; m_rel = 0;
    endtask

    task automatic wait_sig_start(input string tag);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.o_dma_start) break;
        end
        chk({tag, "_start_seen"}, longint'(k < 50), 1);
    endtask

    initial begin
        int t0, t_ren, t_start, target, k, pushed_r, rel_r, ok_base;
        bus.i_cpl_ready = 1'b1;
        do_reset(1'b1);
        enable = 1'b1;
        tick();

        // First packet: latency and ring slot 0.
        push_pkt(64, 1'b1);
        @(negedge clk);
        t0 = cyc;
        for (k = 0; k < 20; k++) begin @(negedge clk); if (bus.o_meta_ren) break; end
        t_ren = cyc;
        for (k = 0; k < 20; k++) begin @(negedge clk); if (bus.o_dma_start) break; end
        t_start = cyc;
        chk("ren_latency", t_ren - t0, 1);
        chk("start_latency", t_start - t_ren, 2);
        wait_idle("first");

        // Exhaust credits: 16 go out, 17th stalls until one release.
        reload("fill");
        target = cpl_cnt + 16;
        for (int i = 0; i < 17; i++) push_pkt(100, 1'b1);
        for (k = 0; k < 3000; k++) begin @(negedge clk); if (cpl_cnt >= target) break; end
        chk("fill_16_done", longint'(cpl_cnt >= target), 1);
        repeat (20) @(negedge clk);
        chk("stall_credits", credits, 0);
        chk("stall_ren", ren_cnt, m_pushed - 1);
        chk("stall_pending", meta_q.size(), 1);
        tick();
        release_p = 1'b1;
        m_rel++;
        tick();
        release_p = 1'b0;
        wait_idle("wrap");

        // Oversize and zero-length drops, then rounding.
        reload("drop");
        push_pkt(3000, 1'b1);
        wait_idle("oversize");
        push_pkt(0, 1'b1);
        wait_idle("zero");
        push_pkt(61, 1'b1);
        wait_idle("round");

        // Release coinciding with a consume at credits=5.
        for (int i = 0; i < 10; i++) push_pkt(100, 1'b1);
        wait_idle("to5");
        push_pkt(100, 1'b1);
        for (k = 0; k < 50; k++) begin @(negedge clk); if (bus.o_meta_ren) break; end
        tick();
        release_p = 1'b1;
        m_rel++;
        tick();
        release_p = 1'b0;
        chk("same_cycle_start", bus.o_dma_start, 1);
        chk("same_cycle_credits", credits, 5);
        wait_idle("same_cycle");

        // Release while full.
        reload("err");
        tick();
        release_p = 1'b1;
        tick();
        release_p = 1'b0;
        chk("credit_err_set", credit_err, 1);
        chk("credit_err_credits", credits, NS);
        reload("err_clr");
        chk("credit_err_cleared", credit_err, 0);

        // Completion back-pressure.
        bus.i_cpl_ready = 1'b0;
        push_pkt(200, 1'b1);
        push_pkt(300, 1'b1);
        for (k = 0; k < 50; k++) begin @(negedge clk); if (bus.o_cpl_valid) break; end
        chk("hold_valid_seen", longint'(k < 50), 1);
        repeat (10) @(negedge clk);
        chk("hold_no_ren", ren_cnt, m_pushed - 1);
        chk("hold_valid", bus.o_cpl_valid, 1);
        tick();
        bus.i_cpl_ready = 1'b1;
        wait_idle("hold");

        // Randomized traffic with releases and back-pressure.
        reload("rand");
        pushed_r = 0;
        rel_r = 0;
        ok_base = cpl_ok_cnt;
        for (int it = 0; it < 20000; it++) begin
            tick();
            release_p = 1'b0;
            bus.i_cpl_ready = ($urandom_range(0, 3) != 0);
            if (pushed_r < 60 && $urandom_range(0, 5) == 0) begin
                push_pkt(rand_len(), 1'b1);
                pushed_r++;
            end
            if (cpl_ok_cnt - ok_base > rel_r && $urandom_range(0, 2) == 0) begin
                release_p = 1'b1;
                rel_r++;
                m_rel++;
            end
            if (pushed_r == 60 && exp_cpl_q.size() == 0 && meta_q.size() == 0 &&
                cpl_ok_cnt - ok_base == rel_r && !release_p) break;
        end
        tick();
        release_p = 1'b0;
        bus.i_cpl_ready = 1'b1;
        wait_idle("rand");

        // DMA done withheld: timeout, HALT, no further pops.
        done_en = 1'b0;
        push_pkt(100, 1'b0);
        wait_sig_start("tmo");
        repeat (TMO + 10) @(negedge clk);
        chk("timeout_set", timeout, 1);
        tick();
        meta_q.push_back(16'd50);
        m_pushed++;
        repeat (30) @(negedge clk);
        chk("halt_no_ren", ren_cnt, m_pushed - 1);

        // Asynchronous reset in the middle of WAIT.
        do_reset(1'b0);
        enable = 1'b1;
        tick();
        push_pkt(100, 1'b0);
        wait_sig_start("midwait");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("midwait");
        clear_model();
        tick();
        rst = 1'b0;
        done_en = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
